// File: rtl/alu_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_arb_pkg
// Description : Shared constants for the ALU arbiter slice. Holds the FSM
//               state encoding and the default sizing of the requester
//               array and ALU datapath.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_arb_pkg;

  // Default sizing: number of requesters and the ALU datapath widths.
  localparam int c_N_REQ_DEF = 4;
  localparam int c_DW_DEF    = 8;
  localparam int c_OPW_DEF   = 3;

  // Sequencer FSM encoding.
  localparam int              c_ST_W    = 2;
  localparam logic [c_ST_W-1:0] c_ST_IDLE = 2'd0;
  localparam logic [c_ST_W-1:0] c_ST_EXEC = 2'd1;
  localparam logic [c_ST_W-1:0] c_ST_RESP = 2'd2;

endpackage
`default_nettype wire

// File: rtl/alu_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_arbiter_if
// Description : Bundle of request, ALU and response signals around the
//               alu_arbiter.
//               slave  - arbiter side (takes requests, drives ALU operands,
//                        returns responses)
//               master - environment side (requesters, ALU, consumer)
//               Signals: req/req_opcode/req_a/req_b, gnt, alu_opcode/alu_a/
//               alu_b, alu_out, rsp_valid/rsp_ready/rsp_data/rsp_id.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_arbiter_if
  import alu_arb_pkg::*;
#(
  parameter int N_REQ = c_N_REQ_DEF,
  parameter int DW    = c_DW_DEF,
  parameter int OPW   = c_OPW_DEF
);
  localparam int IDW = $clog2(N_REQ);

  logic [N_REQ-1:0]     req;
  logic [N_REQ*OPW-1:0] req_opcode;
  logic [N_REQ*DW-1:0]  req_a;
  logic [N_REQ*DW-1:0]  req_b;
  logic [N_REQ-1:0]     gnt;

  logic [OPW-1:0]       alu_opcode;
  logic [DW-1:0]        alu_a;
  logic [DW-1:0]        alu_b;
  logic [DW-1:0]        alu_out;

  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [DW-1:0]        rsp_data;
  logic [IDW-1:0]       rsp_id;

  modport slave (
    input  req, req_opcode, req_a, req_b, alu_out, rsp_ready,
    output gnt, alu_opcode, alu_a, alu_b, rsp_valid, rsp_data, rsp_id
  );

  modport master (
    output req, req_opcode, req_a, req_b, alu_out, rsp_ready,
    input  gnt, alu_opcode, alu_a, alu_b, rsp_valid, rsp_data, rsp_id
  );

endinterface
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational winner search over a request vector.
//               Default: round-robin starting at i_ptr and wrapping modulo
//               N_REQ. With ALU_ARB_FIXED_PRIO_EN defined the pointer port is
//               removed and the lowest requesting index always wins.
//               Ports: i_req (requests), i_ptr (highest-priority index,
//               round-robin only), o_gnt (one-hot winner), o_idx (binary
//               winner), o_any (some request present).
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IDW   = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
`ifndef ALU_ARB_FIXED_PRIO_EN
  input  logic [IDW-1:0]   i_ptr,
`endif
  output logic [N_REQ-1:0] o_gnt,
  output logic [IDW-1:0]   o_idx,
  output logic             o_any
);

  // Candidates are visited from lowest priority to highest so that the
  // last hit, i.e. the highest-priority requester, is the one that sticks.
  always_comb begin
    logic [IDW-1:0] w_j;
    w_j   = '0;
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      w_j = IDW'(k);
`else
      w_j = IDW'((int'(i_ptr) + k) % N_REQ);
`endif
      if (i_req[w_j]) begin
        o_gnt      = '0;
        o_gnt[w_j] = 1'b1;
        o_idx      = w_j;
        o_any      = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_arbiter
// Description : Shares one combinational ALU between N_REQ requesters.
//               A winner is granted (one-cycle gnt pulse) and its operands
//               are registered onto the ALU bus; the ALU result is captured
//               one cycle later and offered on a valid/ready response port
//               tagged with the winner's index. A new grant may overlap the
//               response handshake, giving one result every two cycles.
//               Ports: clk, rst (async, active-high), bus (alu_arbiter_if
//               slave modport).
//               Option: ALU_ARB_FIXED_PRIO_EN selects fixed priority
//               (requester 0 highest) and drops the round-robin pointer.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int N_REQ = c_N_REQ_DEF,
  parameter int DW    = c_DW_DEF,
  parameter int OPW   = c_OPW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  alu_arbiter_if.slave  bus
);

  localparam int IDW = $clog2(N_REQ);

  logic [c_ST_W-1:0] r_state;
  logic [c_ST_W-1:0] w_state_nxt;

  logic [IDW-1:0]    r_win_id;
  logic [OPW-1:0]    r_alu_opcode;
  logic [DW-1:0]     r_alu_a;
  logic [DW-1:0]     r_alu_b;
  logic              r_rsp_valid;
  logic [DW-1:0]     r_rsp_data;
  logic [IDW-1:0]    r_rsp_id;

  logic [N_REQ-1:0]  w_pick_gnt;
  logic [IDW-1:0]    w_pick_idx;
  logic              w_pick_any;
  logic              w_grant_en;
  logic              w_capture;
  logic              w_rsp_done;
  logic [N_REQ-1:0]  w_gnt;

  logic [OPW-1:0]    w_sel_op;
  logic [DW-1:0]     w_sel_a;
  logic [DW-1:0]     w_sel_b;

`ifndef ALU_ARB_FIXED_PRIO_EN
  logic [IDW-1:0]    r_ptr;
`endif

  rr_pick #(
    .N_REQ (N_REQ),
    .IDW   (IDW)
  ) u_pick (
    .i_req (bus.req),
`ifndef ALU_ARB_FIXED_PRIO_EN
    .i_ptr (r_ptr),
`endif
    .o_gnt (w_pick_gnt),
    .o_idx (w_pick_idx),
    .o_any (w_pick_any)
  );

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE: if (w_pick_any) w_state_nxt = c_ST_EXEC;
      c_ST_EXEC: w_state_nxt = c_ST_RESP;
      c_ST_RESP: begin
        if (bus.rsp_ready) begin
          w_state_nxt = w_pick_any ? c_ST_EXEC : c_ST_IDLE;
        end
      end
      default:   w_state_nxt = c_ST_IDLE;
    endcase
  end

  // Grant is combinational so that a grant can land in the same cycle the
  // response is accepted. It is forced low while reset is held so every
  // output sits at its reset value during reset.
  always_comb begin
    w_grant_en = 1'b0;
    w_capture  = 1'b0;
    w_rsp_done = 1'b0;
    w_gnt      = '0;
    case (r_state)
      c_ST_IDLE: w_grant_en = w_pick_any;
      c_ST_EXEC: w_capture  = 1'b1;
      c_ST_RESP: begin
        w_rsp_done = bus.rsp_ready;
        w_grant_en = bus.rsp_ready && w_pick_any;
      end
      default: ;
    endcase
    if (rst) begin
      w_grant_en = 1'b0;
    end
    if (w_grant_en) begin
      w_gnt = w_pick_gnt;
    end
  end

  // ----------------------------------------------------- operand select
  always_comb begin
    w_sel_op = '0;
    w_sel_a  = '0;
    w_sel_b  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_pick_idx == IDW'(i)) begin
        w_sel_op = bus.req_opcode[i*OPW +: OPW];
        w_sel_a  = bus.req_a[i*DW +: DW];
        w_sel_b  = bus.req_b[i*DW +: DW];
      end
    end
  end

  // ----------------------------------------------------------- datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_win_id     <= '0;
      r_alu_opcode <= '0;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_data   <= '0;
      r_rsp_id     <= '0;
    end else begin
      if (w_grant_en) begin
        r_win_id     <= w_pick_idx;
        r_alu_opcode <= w_sel_op;
        r_alu_a      <= w_sel_a;
        r_alu_b      <= w_sel_b;
      end
      // Capture and completion never coincide (EXEC vs RESP), so the
      // ordering here carries no priority.
      if (w_capture) begin
        r_rsp_valid <= 1'b1;
        r_rsp_data  <= bus.alu_out;
        r_rsp_id    <= r_win_id;
      end else if (w_rsp_done) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

`ifndef ALU_ARB_FIXED_PRIO_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (w_grant_en) begin
      if (w_pick_idx == IDW'(N_REQ - 1)) begin
        r_ptr <= '0;
      end else begin
        r_ptr <= w_pick_idx + 1'b1;
      end
    end
  end
`endif

  assign bus.gnt        = w_gnt;
  assign bus.alu_opcode = r_alu_opcode;
  assign bus.alu_a      = r_alu_a;
  assign bus.alu_b      = r_alu_b;
  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_data   = r_rsp_data;
  assign bus.rsp_id     = r_rsp_id;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_arbiter
// Description : Directed self-checking bench for alu_arbiter with a small
//               behavioural ALU (0 add, 1 sub, 2 and, 3 or, 4 xor, 5 a<<1,
//               6 a>>1, 7 pass b) closing the loop on alu_out.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  alu_arbiter_if #(.N_REQ(4), .DW(8), .OPW(3)) bus ();

  alu_arbiter #(.N_REQ(4), .DW(8), .OPW(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  function automatic logic [7:0] f_alu(input logic [2:0] op, input logic [7:0] a,
                                       input logic [7:0] b);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return a << 1;
      3'd6:    return a >> 1;
      default: return b;
    endcase
  endfunction

  assign bus.alu_out = f_alu(bus.alu_opcode, bus.alu_a, bus.alu_b);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_slot(input int i, input logic [2:0] op, input logic [7:0] a,
                          input logic [7:0] b);
    bus.req_opcode[i*3 +: 3] = op;
    bus.req_a[i*8 +: 8]      = a;
    bus.req_b[i*8 +: 8]      = b;
  endtask

  logic [7:0] exp6 [4];

  initial begin
    n_vec = 0;
    n_err = 0;
    exp6[0] = 8'h03;
    exp6[1] = 8'h02;
    exp6[2] = 8'h40;
    exp6[3] = 8'h5A;

    rst            = 1'b1;
    bus.req        = '0;
    bus.req_opcode = '0;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.rsp_ready  = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_gnt", bus.gnt, 0);
    chk("rst_alu_opcode", bus.alu_opcode, 0);
    chk("rst_alu_a", bus.alu_a, 0);
    chk("rst_alu_b", bus.alu_b, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_data", bus.rsp_data, 0);
    chk("rst_rsp_id", bus.rsp_id, 0);
    rst = 1'b0;
    tick();

    // Single request from requester 2: 12 - 30 = 238
    set_slot(2, 3'd1, 8'd12, 8'd30);
    bus.req       = 4'b0100;
    bus.rsp_ready = 1'b1;
    settle();
    chk("single_gnt", bus.gnt, 4'b0100);
    tick();
    bus.req = 4'b0000;
    settle();
    chk("single_gnt_pulse", bus.gnt, 0);
    chk("single_alu_a", bus.alu_a, 12);
    chk("single_alu_b", bus.alu_b, 30);
    chk("single_alu_op", bus.alu_opcode, 1);
    chk("single_exec_valid", bus.rsp_valid, 0);
    tick();
    chk("single_valid", bus.rsp_valid, 1);
    chk("single_id", bus.rsp_id, 2);
    chk("single_data", bus.rsp_data, 238);
    tick();
    chk("single_done_valid", bus.rsp_valid, 0);
    chk("single_idle_gnt", bus.gnt, 0);

`ifndef ALU_ARB_FIXED_PRIO_EN
    // Wrap-around: pointer is 3, requesters 3 and 0 -> 3 then 0
    set_slot(3, 3'd0, 8'd100, 8'd55);
    set_slot(0, 3'd4, 8'hF0, 8'h3C);
    bus.req = 4'b1001;
    settle();
    chk("wrap_gnt3", bus.gnt, 4'b1000);
    tick();
    bus.req = 4'b0001;
    settle();
    chk("wrap_exec_gnt", bus.gnt, 0);
    tick();
    chk("wrap_gnt0", bus.gnt, 4'b0001);
    chk("wrap_id3", bus.rsp_id, 3);
    chk("wrap_data3", bus.rsp_data, 155);
    tick();
    bus.req = 4'b0000;
    settle();
    chk("wrap_exec_valid", bus.rsp_valid, 0);
    chk("wrap_alu_a0", bus.alu_a, 8'hF0);
    tick();
    chk("wrap_id0", bus.rsp_id, 0);
    chk("wrap_data0", bus.rsp_data, 8'hCC);
    tick();
`endif

    // Backpressure: response held 5 cycles, pending request granted on release
    bus.rsp_ready = 1'b0;
    set_slot(1, 3'd2, 8'hAA, 8'h0F);
    bus.req = 4'b0010;
    settle();
    chk("bp_gnt1", bus.gnt, 4'b0010);
    tick();
    set_slot(2, 3'd3, 8'h11, 8'h22);
    bus.req = 4'b0100;
    settle();
    chk("bp_exec_gnt", bus.gnt, 0);
    tick();
    for (int c = 0; c < 5; c++) begin
      chk("bp_valid", bus.rsp_valid, 1);
      chk("bp_id", bus.rsp_id, 1);
      chk("bp_data", bus.rsp_data, 8'h0A);
      chk("bp_no_gnt", bus.gnt, 0);
      if (c < 4) tick();
    end
    bus.rsp_ready = 1'b1;
    settle();
    chk("bp_release_gnt", bus.gnt, 4'b0100);
    tick();
    bus.req = 4'b0000;
    settle();
    chk("bp_exec_valid", bus.rsp_valid, 0);
    tick();
    chk("bp_id2", bus.rsp_id, 2);
    chk("bp_data2", bus.rsp_data, 8'h33);
    tick();

    // Reset one cycle after a grant: operation discarded
    set_slot(1, 3'd0, 8'd7, 8'd8);
    bus.req = 4'b0010;
    settle();
    chk("mid_gnt", bus.gnt, 4'b0010);
    tick();
    bus.req = 4'b0000;
    rst     = 1'b1;
    settle();
    chk("mid_rst_valid", bus.rsp_valid, 0);
    chk("mid_rst_alu_a", bus.alu_a, 0);
    chk("mid_rst_alu_b", bus.alu_b, 0);
    chk("mid_rst_alu_op", bus.alu_opcode, 0);
    chk("mid_rst_data", bus.rsp_data, 0);
    chk("mid_rst_id", bus.rsp_id, 0);
    chk("mid_rst_gnt", bus.gnt, 0);
`ifndef ALU_ARB_FIXED_PRIO_EN
    chk("mid_rst_ptr", dut.r_ptr, 0);
`endif
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_valid_a", bus.rsp_valid, 0);
    tick();
    chk("post_rst_valid_b", bus.rsp_valid, 0);

    // All requesters continuously active, results accepted immediately
    set_slot(0, 3'd0, 8'd1, 8'd2);
    set_slot(1, 3'd5, 8'h81, 8'h00);
    set_slot(2, 3'd6, 8'h81, 8'h00);
    set_slot(3, 3'd7, 8'h00, 8'h5A);
    bus.rsp_ready = 1'b1;
`ifndef ALU_ARB_FIXED_PRIO_EN
    bus.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      settle();
      chk("all_gnt", bus.gnt, 32'd1 << (k % 4));
      if (k > 0) begin
        chk("all_valid", bus.rsp_valid, 1);
        chk("all_id", bus.rsp_id, k - 1);
        chk("all_data", bus.rsp_data, exp6[k-1]);
      end
      tick();
      chk("all_exec_gnt", bus.gnt, 0);
      tick();
    end
`else
    // Fixed priority: 1 and 3 starve behind requester 0
    bus.req = 4'b1011;
    for (int k = 0; k < 5; k++) begin
      settle();
      chk("fix_gnt", bus.gnt, 4'b0001);
      if (k > 0) begin
        chk("fix_id", bus.rsp_id, 0);
        chk("fix_data", bus.rsp_data, exp6[0]);
      end
      tick();
      chk("fix_exec_gnt", bus.gnt, 0);
      tick();
    end
`endif
    bus.req = 4'b0000;
    settle();
    chk("tail_valid", bus.rsp_valid, 1);
    chk("tail_id", bus.rsp_id, 0);
    chk("tail_data", bus.rsp_data, exp6[0]);
    chk("tail_gnt", bus.gnt, 0);
    tick();
    chk("tail_idle_valid", bus.rsp_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_arbiter.md
# alu_arbiter

Round-robin arbiter and sequencer that shares one combinational 8-bit ALU between N_REQ requesters. It accepts per-requester operand/opcode requests, drives the registered operand bus into the ALU, captures the ALU result one cycle later, and returns it with the winning requester's ID over a valid/ready response port. It sits between the requesting datapath blocks and the existing `alu` instance, which is unchanged.

## Interface
- N_REQ, 4, number of requesters (2..8)
- DW, 8, operand/result width (matches ALU)
- OPW, 3, opcode width (matches ALU)
- IDW, $clog2(N_REQ), requester ID width

- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- req  in  N_REQ  per-requester request; held high until granted
- req_opcode  in  N_REQ*OPW  packed opcodes, slice i belongs to requester i
- req_a  in  N_REQ*DW  packed operand a
- req_b  in  N_REQ*DW  packed operand b
- gnt  out  N_REQ  one-hot, one-cycle pulse; operands of granted requester sampled that edge
- alu_opcode  out  OPW  registered opcode to ALU
- alu_a  out  DW  registered operand a to ALU
- alu_b  out  DW  registered operand b to ALU
- alu_out  in  DW  ALU result (combinational from alu_* outputs)
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_data  out  DW  captured ALU result
- rsp_id  out  IDW  requester index that owns rsp_data

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE: if any req, pick winner, pulse gnt[winner], load alu_* from winner's slices, store winner ID, go EXEC. Else stay.
- EXEC: one cycle; alu_out settled. Capture alu_out into rsp_data, ID into rsp_id, set rsp_valid, go RESP.
- RESP: hold rsp_valid/rsp_data/rsp_id stable until rsp_ready. On rsp_ready: if any req this cycle, arbitrate and grant in the same cycle (as IDLE) and go EXEC; else clear rsp_valid, go IDLE.
- Round-robin: pointer ptr (IDW bits) marks highest-priority index; search ptr, ptr+1, … wrapping modulo N_REQ. On each grant ptr <= winner+1 (wrap at N_REQ to 0).
- gnt is zero in every cycle without a grant; never more than one bit set.
- alu_* hold their last value outside grant cycles (no toggling when idle).
- Requests arriving during EXEC/RESP wait; a requester that drops req before grant is simply not considered.

## Timing
- Reset values: gnt=0, alu_opcode=0, alu_a=0, alu_b=0, rsp_valid=0, rsp_data=0, rsp_id=0, ptr=0, state=IDLE.
- Grant edge T: alu_* valid after T. Capture edge T+1: rsp_valid high after T+1. Latency request-to-response 2 cycles from IDLE.
- Throughput with rsp_ready held high and continuous requests: one result per 2 cycles (grant in RESP overlaps handshake).
- rsp_valid falling only after a cycle with rsp_ready=1; rsp_ready while rsp_valid=0 is ignored.
- Reset asserted mid-operation: all outputs return to reset values immediately (async); in-flight operation discarded, no response produced.

## Configuration
- ALU_ARB_FIXED_PRIO_EN defined: round-robin pointer removed; lowest index with req always wins (requester 0 highest). ptr logic not synthesized.
- Undefined (default): round-robin as in Operation.

## Structure
- Package alu_arb_pkg: FSM state encoding (IDLE/EXEC/RESP localparams), default DW/OPW/N_REQ constants.
- Sub-module rr_pick: combinational winner search from req vector and ptr, outputs one-hot grant and binary index; fixed-priority variant selected by the macro inside it.

## Test plan
- Single request: req=4'b0100, a=8'd12, b=8'd30, opcode=3'd1, rsp_ready=1 -> gnt=4'b0100 one cycle, alu_a=12/alu_b=30/alu_opcode=1 next cycle, rsp_valid with rsp_id=2 and rsp_data=bench ALU model output two cycles after grant.
- All four requesting continuously, rsp_ready=1 -> grant order 0,1,2,3,0 with gnt every 2 cycles; each rsp_id matches preceding grant.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid -> rsp_valid/rsp_data/rsp_id stable, no gnt; releasing rsp_ready with req pending grants in that same cycle.
- Wrap-around: ptr=3 after granting 2, req=4'b1001 -> grant 3, then 0.
- Reset mid-EXEC: assert rst one cycle after grant -> rsp_valid never asserts, all outputs 0, ptr=0; first grant after reset honors index 0.
- With ALU_ARB_FIXED_PRIO_EN, req=4'b1011 held -> requester 0 granted repeatedly; 1 and 3 starve.
